// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer peripheral.
// Provides the register word offsets, the TCON bit positions, the IDLE/RUN
// state encoding and a small address-decode helper.
package timer_pkg;

    // Byte offsets of the three timer words relative to the base address
    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;

    // TCON bit positions
    localparam int TCON_EN      = 0;
    localparam int TCON_IRQ_EN  = 1;
    localparam int TCON_STATUS  = 2;
    localparam int TCON_ONESHOT = 3;

    // Value at which the next tick reloads TL from TH instead of incrementing
    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

    // Counter state; RUN is exactly TCON.EN == 1
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

    // True when the low address nibble selects one of the three timer words
    function automatic logic is_timer_word(input logic [3:0] offset);
        logic hit;
        case (offset)
            OFF_TH, OFF_TL, OFF_TCON: hit = 1'b1;
            default:                  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: a 16-bit modulo-PRESCALE counter.
// Ports:
//   clk      system clock
//   reset    synchronous reset, active-low
//   i_clear  restart the count at 0 (used when the timer is enabled)
//   i_run    count enable; the count holds while low
//   o_tick   one-cycle pulse in the cycle the count sits at PRESCALE-1
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] r_count;
    logic        w_last;

    assign w_last = (r_count == LAST);
    assign o_tick = i_run & w_last;

    // Modulo counter: clear has priority, otherwise count while running
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_run) begin
            r_count <= w_last ? 16'd0 : (r_count + 16'd1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer peripheral on the CPU MEM-stage peripheral bus.
// Words: TH (reload value), TL (counter), TCON (EN, IRQ_EN, STATUS, ONESHOT).
// TL advances once per prescaler tick while enabled; on a tick with TL at
// all-ones it reloads from TH and sets the sticky STATUS flag.
// Ports:
//   clk           system clock
//   reset         synchronous reset, active-low
//   i_address     byte address from the EX/MEM ALU result
//   i_read        read strobe
//   i_write       write strobe
//   i_write_data  store data
//   o_read_data   combinational read data, 0 when not a read hit
//   o_hit         address decodes to TH, TL or TCON
//   o_irq         IRQ_EN & STATUS, registered
module mmio_timer
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_hit,
    output logic        o_irq
);

    timer_state_e r_state;
    timer_state_e w_state_next;
    logic [31:0]  r_th;
    logic [31:0]  r_tl;
    logic         r_irq_en;
    logic         r_status;
    logic         r_oneshot;
    logic         r_irq;

    logic [31:0]  w_th_next;
    logic [31:0]  w_tl_next;
    logic         w_irq_en_next;
    logic         w_status_next;
    logic         w_oneshot_next;
    logic [31:0]  w_read_data;

    logic [3:0]   w_offset;
    logic         w_hit;
    logic         w_wr_th;
    logic         w_wr_tl;
    logic         w_wr_tcon;
    logic         w_run;
    logic         w_tick;
    logic         w_overflow;
    logic         w_psc_clear;
    logic [31:0]  w_tcon;

    assign w_offset  = i_address[3:0];
    assign w_hit     = (i_address[31:4] == BASE_ADDR[31:4]) && is_timer_word(w_offset);
    assign w_wr_th   = i_write & w_hit & (w_offset == OFF_TH);
    assign w_wr_tl   = i_write & w_hit & (w_offset == OFF_TL);
    assign w_wr_tcon = i_write & w_hit & (w_offset == OFF_TCON);
    assign w_run     = (r_state == ST_RUN);
    assign w_tcon    = {28'd0, r_oneshot, r_status, r_irq_en, w_run};

    // Only a 0->1 EN write restarts the prescaler; rewriting EN=1 while
    // running leaves the phase alone.
    assign w_psc_clear = w_wr_tcon & i_write_data[TCON_EN] & ~w_run;

    // A CPU write to TL replaces the whole tick effect, reload included
    assign w_overflow = w_tick & (r_tl == TL_MAX) & ~w_wr_tl;

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_psc_clear),
        .i_run   (w_run),
        .o_tick  (w_tick)
    );

    // Next state: a TCON write always decides EN; otherwise a one-shot overflow stops the timer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_tcon && i_write_data[TCON_EN]) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_wr_tcon) begin
                    w_state_next = i_write_data[TCON_EN] ? ST_RUN : ST_IDLE;
                end else if (w_overflow && r_oneshot) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Register next values; reload reads the old TH, overflow beats the W1C of STATUS
    always_comb begin
        w_th_next      = r_th;
        w_tl_next      = r_tl;
        w_irq_en_next  = r_irq_en;
        w_status_next  = r_status;
        w_oneshot_next = r_oneshot;

        if (w_wr_th) begin
            w_th_next = i_write_data;
        end else begin
            w_th_next = r_th;
        end

        if (w_wr_tl) begin
            w_tl_next = i_write_data;
        end else if (w_tick) begin
            w_tl_next = (r_tl == TL_MAX) ? r_th : (r_tl + 32'd1);
        end else begin
            w_tl_next = r_tl;
        end

        if (w_overflow) begin
            w_status_next = 1'b1;
        end else if (w_wr_tcon && i_write_data[TCON_STATUS]) begin
            w_status_next = 1'b0;
        end else begin
            w_status_next = r_status;
        end

        if (w_wr_tcon) begin
            w_irq_en_next  = i_write_data[TCON_IRQ_EN];
            w_oneshot_next = i_write_data[TCON_ONESHOT];
        end else begin
            w_irq_en_next  = r_irq_en;
            w_oneshot_next = r_oneshot;
        end
    end

    // Read mux: zero unless this is a read of one of the timer words
    always_comb begin
        w_read_data = 32'd0;
        if (i_read && w_hit) begin
            case (w_offset)
                OFF_TH:   w_read_data = r_th;
                OFF_TL:   w_read_data = r_tl;
                OFF_TCON: w_read_data = w_tcon;
                default:  w_read_data = 32'd0;
            endcase
        end else begin
            w_read_data = 32'd0;
        end
    end

    // State and register file; o_irq is registered from the next-state values
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_th      <= 32'd0;
            r_tl      <= 32'd0;
            r_irq_en  <= 1'b0;
            r_status  <= 1'b0;
            r_oneshot <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_th      <= w_th_next;
            r_tl      <= w_tl_next;
            r_irq_en  <= w_irq_en_next;
            r_status  <= w_status_next;
            r_oneshot <= w_oneshot_next;
            r_irq     <= w_irq_en_next & w_status_next;
        end
    end

    assign o_read_data = w_read_data;
    assign o_hit       = w_hit;
    assign o_irq       = r_irq;

endmodule
